// File: rtl/node_rr_scheduler.sv
// Round-robin front end that time-shares one start/ready computation node among
// NREQ requesters, with operand capture, per-requester completion pulses and a watchdog.
module node_rr_scheduler #(
  parameter int W       = 16,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*W-1:0] arg0_i,
  input  logic [NREQ*W-1:0] arg1_i,
  input  logic [NREQ*W-1:0] arg2_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   done_o,
  output logic [W-1:0]      res_o,
  output logic              err_o,
  output logic              busy_o,
  output logic              node_st_o,
  input  logic              node_rd_i,
  output logic [W-1:0]      node_in0_o,
  output logic [W-1:0]      node_in1_o,
  output logic [W-1:0]      node_in2_o,
  input  logic [W-1:0]      node_res_i
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [W-1:0]    res_q, res_d;
  logic            err_q, err_d;
  logic            st_q, st_d;
  logic [W-1:0]    in0_q, in0_d;
  logic [W-1:0]    in1_q, in1_d;
  logic [W-1:0]    in2_q, in2_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [PW-1:0]   win;
  logic            win_vld;

  // Search starts just after the last winner so every requester gets its turn.
  always_comb begin
    win     = ptr_q;
    win_vld = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_vld && req_i[(int'(ptr_q) + k) % NREQ]) begin
        win_vld = 1'b1;
        win     = PW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    res_d   = res_q;
    err_d   = err_q;
    st_d    = st_q;
    in0_d   = in0_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          ptr_d   = win;
          gnt_d   = NREQ'(1) << win;
          in0_d   = arg0_i[win*W +: W];
          in1_d   = arg1_i[win*W +: W];
          in2_d   = arg2_i[win*W +: W];
          st_d    = 1'b1;
          timer_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (TIMEOUT != 0) timer_d = timer_q + 1'b1;
        // A ready node wins over a watchdog expiry in the same cycle.
        if (node_rd_i) begin
          res_d   = node_res_i;
          err_d   = 1'b0;
          done_d  = gnt_q;
          st_d    = 1'b0;
          state_d = RELEASE;
        end else if (TIMEOUT != 0 && timer_q == TLAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          done_d  = gnt_q;
          st_d    = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Hold the grant until the node has dropped ready, so it is fully re-armed.
        if (!node_rd_i) begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NREQ - 1);
      gnt_q   <= '0;
      done_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      st_q    <= 1'b0;
      in0_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      res_q   <= res_d;
      err_q   <= err_d;
      st_q    <= st_d;
      in0_q   <= in0_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      timer_q <= timer_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign res_o      = res_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q != IDLE);
  assign node_st_o  = st_q;
  assign node_in0_o = in0_q;
  assign node_in1_o = in1_q;
  assign node_in2_o = in2_q;

endmodule
